// File: rtl/mem_access_unit.sv
// Memory-stage access unit: turns byte/half/word/double loads and stores into
// doubleword-aligned memory transactions (read-modify-write for partial stores).
module mem_access_unit #(
   parameter int ADDR_W = 64
) (
   input  logic              CLK,
   input  logic              reset_n,
   input  logic              req_v,
   input  logic              req_st,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [63:0]       req_wdata,
   output logic              req_ready,
   output logic              resp_v,
   output logic [63:0]       resp_data,
   output logic              resp_misaligned,
   output logic              MEM_V,
   output logic              we,
   output logic [1:0]        size,
   output logic [ADDR_W-1:0] address,
   output logic [63:0]       mem_data,
   input  logic              v_mem_stall,
   input  logic [63:0]       data_out,
   output logic [2:0]        o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_RMW_RD = 3'd2,
      S_WR     = 3'd3,
      S_RESP   = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [1:0]          r_sz;
   logic                r_uns;
   logic [ADDR_W-1:0]   r_addr;
   logic [63:0]         r_wdata;
   logic [63:0]         r_buf;
   logic [63:0]         r_resp_data;
   logic                r_fault;

   logic                w_accept;
   logic                w_misaligned;
   logic [7:0]          w_base_mask;
   logic [7:0]          w_lane_mask;
   logic [63:0]         w_byte_mask;
   logic [63:0]         w_wdata_sh;
   logic [63:0]         w_merged;
   logic [63:0]         w_shifted;
   logic [63:0]         w_load_data;

   assign w_accept = (r_state == S_IDLE) && req_v;

   always_comb begin
      w_misaligned = 1'b0;
      case (req_size)
         2'b01:   w_misaligned = req_addr[0];
         2'b10:   w_misaligned = |req_addr[1:0];
         2'b11:   w_misaligned = |req_addr[2:0];
         default: w_misaligned = 1'b0;
      endcase
   end

   // Byte lanes off..off+nbytes-1 of the doubleword take the store data.
   always_comb begin
      w_base_mask = 8'h01;
      case (r_sz)
         2'b00:   w_base_mask = 8'h01;
         2'b01:   w_base_mask = 8'h03;
         2'b10:   w_base_mask = 8'h0F;
         default: w_base_mask = 8'hFF;
      endcase
      w_lane_mask = w_base_mask << r_addr[2:0];
      w_byte_mask = '0;
      for (int i = 0; i < 8; i++) begin
         w_byte_mask[i*8 +: 8] = {8{w_lane_mask[i]}};
      end
      w_wdata_sh = r_wdata << {r_addr[2:0], 3'b000};
      w_merged   = (data_out & ~w_byte_mask) | (w_wdata_sh & w_byte_mask);
   end

   always_comb begin
      w_shifted   = data_out >> {r_addr[2:0], 3'b000};
      w_load_data = w_shifted;
      case (r_sz)
         2'b00:   w_load_data = r_uns ? {56'd0, w_shifted[7:0]}
                                      : {{56{w_shifted[7]}}, w_shifted[7:0]};
         2'b01:   w_load_data = r_uns ? {48'd0, w_shifted[15:0]}
                                      : {{48{w_shifted[15]}}, w_shifted[15:0]};
         2'b10:   w_load_data = r_uns ? {32'd0, w_shifted[31:0]}
                                      : {{32{w_shifted[31]}}, w_shifted[31:0]};
         default: w_load_data = w_shifted;
      endcase
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (req_v) begin
               if (w_misaligned)           w_next = S_RESP;
               else if (!req_st)           w_next = S_LOAD;
               else if (req_size == 2'b11) w_next = S_WR;
               else                        w_next = S_RMW_RD;
            end
         end
         S_LOAD:   if (!v_mem_stall) w_next = S_RESP;
         S_RMW_RD: if (!v_mem_stall) w_next = S_WR;
         S_WR:     if (!v_mem_stall) w_next = S_RESP;
         S_RESP:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // resp_data only changes on the edge that enters RESP.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         r_sz        <= 2'b00;
         r_uns       <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_buf       <= '0;
         r_resp_data <= '0;
         r_fault     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_sz    <= req_size;
            r_uns   <= req_unsigned;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_fault <= w_misaligned;
            if (w_misaligned) r_resp_data <= '0;
            if (req_st && (req_size == 2'b11)) r_buf <= req_wdata;
         end
         case (r_state)
            S_LOAD:   if (!v_mem_stall) r_resp_data <= w_load_data;
            S_RMW_RD: if (!v_mem_stall) r_buf <= w_merged;
            S_WR:     if (!v_mem_stall) r_resp_data <= '0;
            S_RESP:   r_fault <= 1'b0;
            default:  ;
         endcase
      end
   end

   always_comb begin
      req_ready       = (r_state == S_IDLE) && reset_n;
      resp_v          = (r_state == S_RESP);
      resp_data       = r_resp_data;
      resp_misaligned = r_fault;
      MEM_V           = 1'b0;
      we              = 1'b0;
      size            = 2'b00;
      address         = '0;
      mem_data        = '0;
      o_dbg_state     = r_state;
      if ((r_state == S_LOAD) || (r_state == S_RMW_RD) || (r_state == S_WR)) begin
         MEM_V   = 1'b1;
         size    = 2'b11;
         address = {r_addr[ADDR_W-1:3], 3'b000};
      end
      if (r_state == S_WR) begin
         we       = 1'b1;
         mem_data = r_buf;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small doubleword memory model.
module tb_mem_access_unit;

   logic        CLK = 1'b0;
   logic        reset_n;
   logic        req_v;
   logic        req_st;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        req_ready;
   logic        resp_v;
   logic [63:0] resp_data;
   logic        resp_misaligned;
   logic        MEM_V;
   logic        we;
   logic [1:0]  size;
   logic [63:0] address;
   logic [63:0] mem_data;
   logic        v_mem_stall;
   logic [63:0] data_out;
   logic [2:0]  o_dbg_state;

   logic [63:0] mem [0:15];
   int n_pass  = 0;
   int n_total = 0;
   int lat;

   always #5 CLK = ~CLK;

   mem_access_unit #(.ADDR_W(64)) dut (
      .CLK(CLK), .reset_n(reset_n), .req_v(req_v), .req_st(req_st),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(req_ready), .resp_v(resp_v),
      .resp_data(resp_data), .resp_misaligned(resp_misaligned), .MEM_V(MEM_V),
      .we(we), .size(size), .address(address), .mem_data(mem_data),
      .v_mem_stall(v_mem_stall), .data_out(data_out), .o_dbg_state(o_dbg_state)
   );

   assign data_out = mem[address[6:3]];

   always @(posedge CLK) begin
      if (MEM_V && we && !v_mem_stall) mem[address[6:3]] <= mem_data;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic mid();
      @(negedge CLK);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Called just after a clock edge; returns just after the accept edge.
   task automatic issue(input logic st, input logic [1:0] sz, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wdata);
      req_v        = 1'b1;
      req_st       = st;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      mid();
      chk("ready_at_issue", {63'd0, req_ready}, 64'd1);
      tick();
      req_v = 1'b0;
   endtask

   task automatic load_check(input string tag, input logic [1:0] sz, input logic uns,
                             input logic [63:0] addr, input logic [63:0] exp);
      issue(1'b0, sz, uns, addr, 64'd0);
      mid();
      chk({tag, "_memv"}, {63'd0, MEM_V}, 64'd1);
      chk({tag, "_we"}, {63'd0, we}, 64'd0);
      chk({tag, "_addr"}, address, {addr[63:3], 3'b000});
      tick();
      mid();
      chk({tag, "_respv"}, {63'd0, resp_v}, 64'd1);
      chk({tag, "_data"}, resp_data, exp);
      tick();
   endtask

   initial begin
      reset_n      = 1'b0;
      req_v        = 1'b0;
      req_st       = 1'b0;
      req_size     = 2'b00;
      req_unsigned = 1'b0;
      req_addr     = '0;
      req_wdata    = '0;
      v_mem_stall  = 1'b0;

      tick();
      tick();
      mid();
      chk("rst_ready", {63'd0, req_ready}, 64'd0);
      chk("rst_memv", {63'd0, MEM_V}, 64'd0);
      chk("rst_respv", {63'd0, resp_v}, 64'd0);
      chk("rst_data", resp_data, 64'd0);
      tick();
      reset_n = 1'b1;
      mid();
      chk("post_rst_ready", {63'd0, req_ready}, 64'd1);
      chk("post_rst_memv", {63'd0, MEM_V}, 64'd0);
      chk("post_rst_state", {61'd0, o_dbg_state}, 64'd0);
      tick();

      // Double store at 0x8: single WR cycle, response two cycles after accept.
      issue(1'b1, 2'b11, 1'b0, 64'h8, 64'h8899AABBCCDDEEFF);
      mid();
      chk("dst_memv", {63'd0, MEM_V}, 64'd1);
      chk("dst_we", {63'd0, we}, 64'd1);
      chk("dst_size", {62'd0, size}, 64'd3);
      chk("dst_addr", address, 64'h8);
      chk("dst_wdata", mem_data, 64'h8899AABBCCDDEEFF);
      tick();
      mid();
      chk("dst_respv", {63'd0, resp_v}, 64'd1);
      chk("dst_mis", {63'd0, resp_misaligned}, 64'd0);
      chk("dst_data", resp_data, 64'd0);
      chk("dst_memv_off", {63'd0, MEM_V}, 64'd0);
      tick();

      load_check("lb_b", 2'b00, 1'b0, 64'hB, 64'hFFFFFFFFFFFFFFCC);
      load_check("lhu_e", 2'b01, 1'b1, 64'hE, 64'h0000000000008899);
      load_check("lwu_c", 2'b10, 1'b1, 64'hC, 64'h000000008899AABB);

      // Byte store at 0xA goes through read-modify-write.
      issue(1'b1, 2'b00, 1'b0, 64'hA, 64'h000000000000005A);
      mid();
      chk("rmw_rd_memv", {63'd0, MEM_V}, 64'd1);
      chk("rmw_rd_we", {63'd0, we}, 64'd0);
      chk("rmw_rd_mdata", mem_data, 64'd0);
      tick();
      mid();
      chk("rmw_wr_we", {63'd0, we}, 64'd1);
      chk("rmw_wr_mdata", mem_data, 64'h8899AABBCC5AEEFF);
      tick();
      mid();
      chk("rmw_respv", {63'd0, resp_v}, 64'd1);
      chk("rmw_data", resp_data, 64'd0);
      tick();

      load_check("lw_8", 2'b10, 1'b0, 64'h8, 64'hFFFFFFFFCC5AEEFF);

      // Misaligned half load: fault response next cycle, memory untouched.
      issue(1'b0, 2'b01, 1'b0, 64'h3, 64'd0);
      mid();
      chk("mis_respv", {63'd0, resp_v}, 64'd1);
      chk("mis_flag", {63'd0, resp_misaligned}, 64'd1);
      chk("mis_data", resp_data, 64'd0);
      chk("mis_memv", {63'd0, MEM_V}, 64'd0);
      tick();
      mid();
      chk("mis_flag_clear", {63'd0, resp_misaligned}, 64'd0);
      tick();

      // Three stalled LOAD cycles, then the read completes.
      v_mem_stall = 1'b1;
      issue(1'b0, 2'b11, 1'b0, 64'h8, 64'd0);
      lat = 0;
      for (int k = 1; k <= 10 && lat == 0; k++) begin
         mid();
         if (k <= 3) begin
            chk("stall_memv", {63'd0, MEM_V}, 64'd1);
            chk("stall_addr", address, 64'h8);
         end
         if (resp_v) lat = k;
         else begin
            tick();
            if (k == 3) v_mem_stall = 1'b0;
         end
      end
      v_mem_stall = 1'b0;
      chk("stall_latency", 64'(lat), 64'd5);
      chk("stall_data", resp_data, 64'h8899AABBCC5AEEFF);
      tick();

      // Reset dropped during WR must abort the write.
      issue(1'b1, 2'b00, 1'b0, 64'h9, 64'h0000000000000077);
      tick();
      mid();
      chk("rstwr_we", {63'd0, we}, 64'd1);
      #1 reset_n = 1'b0;
      #1;
      chk("rstwr_memv", {63'd0, MEM_V}, 64'd0);
      chk("rstwr_we_off", {63'd0, we}, 64'd0);
      chk("rstwr_addr", address, 64'd0);
      chk("rstwr_mdata", mem_data, 64'd0);
      chk("rstwr_size", {62'd0, size}, 64'd0);
      chk("rstwr_ready", {63'd0, req_ready}, 64'd0);
      tick();
      reset_n = 1'b1;
      mid();
      chk("rstwr_ready_back", {63'd0, req_ready}, 64'd1);
      tick();
      load_check("ld_after_rst", 2'b11, 1'b0, 64'h8, 64'h8899AABBCC5AEEFF);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage initiator that drives the data-memory request interface (`MEM_V`, `we`, `size`, `address`, `mem_data`, `v_mem_stall`, `data_out`) on behalf of the pipeline. It turns RISC-V byte/half/word/double loads and stores into doubleword-aligned memory transactions. Sub-doubleword stores use a read-modify-write sequence, and load data is lane-shifted and sign- or zero-extended. Misaligned requests are rejected without touching memory.

## Interface
- `ADDR_W`, default 64: address width. Data path is fixed at 64 bits.

- `CLK` in 1: clock, rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `req_v` in 1: pipeline request valid.
- `req_st` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 double.
- `req_unsigned` in 1: 1 = zero-extend load result.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 64: store data, right-justified.
- `req_ready` out 1: unit idle, request accepted this cycle if `req_v`.
- `resp_v` out 1: one-cycle completion pulse.
- `resp_data` out 64: extended load result; 0 for stores and faults.
- `resp_misaligned` out 1: valid with `resp_v`; request faulted.
- `MEM_V` out 1: memory request valid.
- `we` out 1: memory write enable.
- `size` out 2: memory access size; always 11 from this unit.
- `address` out ADDR_W: `{addr[ADDR_W-1:3], 3'b000}`.
- `mem_data` out 64: write data.
- `v_mem_stall` in 1: memory not accepting; hold request.
- `data_out` in 64: combinational read data for the doubleword at `address`.

## Operation
- Request capture: on `req_v & req_ready`, latch `st`, `sz`, `uns`, `addr`, `wdata`. Let `off = addr[2:0]` and `nbytes = 1 << sz`.
- Misaligned condition:
  - half: `addr[0] != 0`
  - word: `addr[1:0] != 0`
  - double: `addr[2:0] != 0`
  - Because naturally aligned accesses never cross a doubleword, no split is ever needed.
- FSM states: IDLE, LOAD, RMW_RD, WR, RESP.
  - IDLE: `req_ready=1`. On accept:
    - misaligned → RESP
    - load → LOAD
    - store with `sz=11` → WR, with buffer = `wdata`
    - other store → RMW_RD
  - LOAD: `MEM_V=1`, `we=0`.
    - `v_mem_stall=1`: stay.
    - Otherwise: `shifted = data_out >> (8*off)`; keep the low `nbytes` bytes; sign-extend from their top bit unless `uns` (double is passed through); write to `resp_data`; go to RESP.
  - RMW_RD: `MEM_V=1`, `we=0`.
    - `v_mem_stall=1`: stay.
    - Otherwise: buffer = `data_out` with byte lanes `off .. off+nbytes-1` replaced by `wdata` bytes `0 .. nbytes-1`; go to WR.
  - WR: `MEM_V=1`, `we=1`, `mem_data` = buffer.
    - `v_mem_stall=1`: stay.
    - Otherwise the write commits on this edge; go to RESP.
  - RESP: `resp_v=1`, `req_ready=0`; go to IDLE.
- Output gating:
  - `resp_misaligned` = latched fault flag.
  - `resp_data` holds its value until the next response. It is set to 0 on store and fault responses.
  - When `MEM_V=0`, `we`, `size`, `address` and `mem_data` are driven 0.
- Reset:
  - `reset_n=0` forces IDLE immediately, asynchronously.
  - All outputs go to 0 except `req_ready`, which is 1 in IDLE once `reset_n` is high. `req_ready` is 0 while `reset_n` is low.
  - The in-flight transaction is abandoned. A reset asserted before the WR edge prevents the write.

## Timing
- Memory request outputs come from registered state only and are stable for the whole state, including every stall cycle.
- Latency from the accept edge to the `resp_v` cycle (0 stall):
  - misaligned: 1 cycle
  - load: 2 cycles
  - double store: 2 cycles
  - sub-doubleword store: 3 cycles
  - Each stalled cycle adds 1.
- Back-to-back: the next request is accepted in the IDLE cycle after RESP, so throughput is one request per latency+1 cycles.
- `req_v` during non-IDLE states is ignored; the pipeline holds the request until `req_ready`.

## Test plan
- Reset: assert `reset_n=0` mid-cycle → all outputs 0 immediately; after release, `req_ready=1`, `MEM_V=0`.
- Double store then loads:
  - Store `0x8899AABBCCDDEEFF` at `0x8` → one WR cycle with `address=0x8`, `size=11`, `we=1`; `resp_v` 2 cycles after accept.
  - Signed byte load at `0xB` → `0xFFFFFFFFFFFFFFCC`.
  - Unsigned half load at `0xE` → `0x0000000000008899`.
- RMW store: byte `0x5A` at `0xA` → read cycle, then write cycle with `mem_data=0x8899AABBCC5AEEFF`. A signed word load at `0x8` then → `0xFFFFFFFFCC5AEEFF`.
- Misaligned: half load at `0x3` → `resp_v=1`, `resp_misaligned=1`, `resp_data=0` one cycle after accept; `MEM_V` never asserted.
- Stall: `v_mem_stall` high for 3 cycles in LOAD → `MEM_V`/`address` held constant; `resp_v` arrives at cycle 5 after accept with correct data.
- Reset mid-RMW: drop `reset_n` during WR before the edge → outputs 0 at once; a subsequent load shows the doubleword unchanged.
